// File: rtl/reversi_pkg.sv
// Shared Reversi board constants, winner encodings and score sequencer states.
package reversi_pkg;

  localparam int N_SQ      = 64;
  localparam int ROW_W     = 8;
  localparam int N_ROWS    = N_SQ / ROW_W;
  localparam int ROW_IDX_W = $clog2(N_ROWS);
  localparam int CNT_W     = $clog2(ROW_W + 1);
  localparam int TOT_W     = 8;

  localparam logic [1:0] WIN_DRAW  = 2'b00;
  localparam logic [1:0] WIN_WHITE = 2'b01;
  localparam logic [1:0] WIN_BLACK = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/row_popcnt.sv
// Combinational population count of one board row (0..ROW_W set squares).
module row_popcnt
  import reversi_pkg::*;
(
  input  logic [ROW_W-1:0] row_bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < ROW_W; i++) begin
      count = count + CNT_W'(row_bits[i]);
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// Reversi stone counter: latches both boards, counts one row per cycle through
// a shared pair of row popcounts, then registers totals, winner and sanity flags.
module score_ctrl
  import reversi_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_SQ-1:0] white_data,
  input  logic [N_SQ-1:0] black_data,
  output logic            busy,
  output logic            done,
  output logic [TOT_W-1:0] cnt_white,
  output logic [TOT_W-1:0] cnt_black,
  output logic [TOT_W-1:0] cnt_empty,
  output logic [1:0]      winner,
  output logic            board_full,
  output logic            err_overlap
);

  state_t                state, state_nxt;
  logic [ROW_IDX_W-1:0]  row;
  logic [N_SQ-1:0]       shadow_w, shadow_b;
  logic [TOT_W-1:0]      acc_w, acc_b;
  logic                  ovl;

  logic [ROW_W-1:0]      row_w_bits, row_b_bits;
  logic [CNT_W-1:0]      pc_w, pc_b;
  logic [TOT_W-1:0]      tot_w, tot_b, tot_sum, empty_nxt;
  logic [1:0]            winner_nxt;
  logic                  ovl_nxt, last_row;

  assign row_w_bits = shadow_w[int'(row) * ROW_W +: ROW_W];
  assign row_b_bits = shadow_b[int'(row) * ROW_W +: ROW_W];

  row_popcnt u_pc_white (.row_bits(row_w_bits), .count(pc_w));
  row_popcnt u_pc_black (.row_bits(row_b_bits), .count(pc_b));

  // Totals including the row being processed this cycle; only committed on the last row.
  assign tot_w    = acc_w + TOT_W'(pc_w);
  assign tot_b    = acc_b + TOT_W'(pc_b);
  assign tot_sum  = tot_w + tot_b;
  assign ovl_nxt  = ovl | (|(row_w_bits & row_b_bits));
  assign last_row = (row == ROW_IDX_W'(N_ROWS - 1));

  // Overlapping boards can exceed N_SQ stones; clamp empties at zero.
  always_comb begin
    empty_nxt = '0;
    if (tot_sum <= TOT_W'(N_SQ)) empty_nxt = TOT_W'(N_SQ) - tot_sum;
    winner_nxt = WIN_DRAW;
    if (tot_w > tot_b)      winner_nxt = WIN_WHITE;
    else if (tot_b > tot_w) winner_nxt = WIN_BLACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_COUNT;
      S_COUNT: if (last_row) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row         <= '0;
      shadow_w    <= '0;
      shadow_b    <= '0;
      acc_w       <= '0;
      acc_b       <= '0;
      ovl         <= 1'b0;
      cnt_white   <= '0;
      cnt_black   <= '0;
      cnt_empty   <= '0;
      winner      <= WIN_DRAW;
      board_full  <= 1'b0;
      err_overlap <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow_w <= white_data;
            shadow_b <= black_data;
            acc_w    <= '0;
            acc_b    <= '0;
            ovl      <= 1'b0;
            row      <= '0;
          end
        end
        S_COUNT: begin
          acc_w <= tot_w;
          acc_b <= tot_b;
          ovl   <= ovl_nxt;
          row   <= row + 1'b1;
          if (last_row) begin
            cnt_white   <= tot_w;
            cnt_black   <= tot_b;
            cnt_empty   <= empty_nxt;
            winner      <= winner_nxt;
            board_full  <= (empty_nxt == '0);
            err_overlap <= ovl_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// Directed-vector bench for score_ctrl with hand-computed expected results.
module tb_score_ctrl;
  import reversi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] white_data = '0;
  logic [63:0] black_data = '0;
  logic        busy, done, board_full, err_overlap;
  logic [7:0]  cnt_white, cnt_black, cnt_empty;
  logic [1:0]  winner;

  int checks = 0;
  int failures = 0;

  logic [7:0] pw = '0, pb = '0, pe = '0;
  logic [1:0] pwin = '0;
  logic       pf = 1'b0, po = 1'b0;

  score_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .white_data(white_data), .black_data(black_data),
    .busy(busy), .done(done),
    .cnt_white(cnt_white), .cnt_black(cnt_black), .cnt_empty(cnt_empty),
    .winner(winner), .board_full(board_full), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [7:0] ew, input logic [7:0] eb,
                               input logic [7:0] ee, input logic [1:0] ewin,
                               input logic ef, input logic eo);
    check({tag, ".cnt_white"}, 64'(cnt_white), 64'(ew));
    check({tag, ".cnt_black"}, 64'(cnt_black), 64'(eb));
    check({tag, ".cnt_empty"}, 64'(cnt_empty), 64'(ee));
    check({tag, ".winner"}, 64'(winner), 64'(ewin));
    check({tag, ".board_full"}, 64'(board_full), 64'(ef));
    check({tag, ".err_overlap"}, 64'(err_overlap), 64'(eo));
  endtask

  task automatic run_and_check(input string tag, input logic [63:0] w, input logic [63:0] b,
                               input logic [7:0] ew, input logic [7:0] eb, input logic [7:0] ee,
                               input logic [1:0] ewin, input logic ef, input logic eo);
    @(negedge clk);
    white_data = w;
    black_data = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    white_data = ~w;
    check({tag, ".busy_T"}, 64'(busy), 64'd1);
    check({tag, ".done_T"}, 64'(done), 64'd0);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk);
      #1;
      check({tag, ".done_early"}, 64'(done), 64'd0);
      check_results({tag, ".hold"}, pw, pb, pe, pwin, pf, po);
    end
    @(posedge clk);
    #1;
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy_done"}, 64'(busy), 64'd1);
    check_results(tag, ew, eb, ee, ewin, ef, eo);
    pw = ew; pb = eb; pe = ee; pwin = ewin; pf = ef; po = eo;
    @(posedge clk);
    #1;
    check({tag, ".done_clr"}, 64'(done), 64'd0);
    check({tag, ".busy_clr"}, 64'(busy), 64'd0);
  endtask

  localparam logic [63:0] OPEN_W = 64'h0000_0010_0800_0000;
  localparam logic [63:0] OPEN_B = 64'h0000_0008_1000_0000;

  initial begin
    int dn;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check_results("reset", 8'd0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_and_check("open", OPEN_W, OPEN_B, 8'd2, 8'd2, 8'd60, 2'b00, 1'b0, 1'b0);
    run_and_check("full_w", '1, '0, 8'd64, 8'd0, 8'd0, 2'b01, 1'b1, 1'b0);
    run_and_check("split", 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF,
                  8'd32, 8'd32, 8'd0, 2'b00, 1'b1, 1'b0);
    run_and_check("ovl_row", 64'hFF, 64'hFF, 8'd8, 8'd8, 8'd48, 2'b00, 1'b0, 1'b1);
    run_and_check("ovl_all", '1, '1, 8'd64, 8'd64, 8'd0, 2'b00, 1'b1, 1'b1);

    // Start held high, black board changes after the boards were latched.
    @(negedge clk);
    white_data = OPEN_W;
    black_data = OPEN_B;
    start = 1'b1;
    @(posedge clk);
    #1;
    dn = 0;
    for (int e = 1; e <= 18; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) black_data = '1;
      if (done) dn++;
      if (e == 8) check_results("held1", 8'd2, 8'd2, 8'd60, 2'b00, 1'b0, 1'b0);
      if (e == 9) check("held.idle_gap", 64'(busy), 64'd0);
      if (e == 10) check("held.restart_busy", 64'(busy), 64'd1);
      if (e == 18) begin
        check("held.done2", 64'(done), 64'd1);
        check_results("held2", 8'd2, 8'd64, 8'd0, 2'b10, 1'b1, 1'b1);
      end
    end
    start = 1'b0;
    check("held.done_count", 64'(dn), 64'd2);
    pw = 8'd2; pb = 8'd64; pe = 8'd0; pwin = 2'b10; pf = 1'b1; po = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("held.idle_after", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of a count.
    @(negedge clk);
    white_data = OPEN_W;
    black_data = OPEN_B;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check_results("rst_mid", 8'd0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b0);
    pw = '0; pb = '0; pe = '0; pwin = '0; pf = 1'b0; po = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_mid.no_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("post_rst", OPEN_W, OPEN_B, 8'd2, 8'd2, 8'd60, 2'b00, 1'b0, 1'b0);

    run_and_check("black_win", 64'h1, 64'h6, 8'd1, 8'd2, 8'd61, 2'b10, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Sequenced stone counter and result evaluator for the Reversi board.
- On a start request it latches the white and black 64-bit occupancy boards and counts one 8-square row per cycle through a shared row popcount.
- It reports the stone totals, the empty count, the winner and a board-sanity flag.
- The game FSM uses it at end-of-turn and end-of-game; the display uses its registered counts.

Parameters:
- N_SQ, 64, number of board squares.
- ROW_W, 8, squares counted per cycle. N_SQ/ROW_W = 8 count cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  count request, sampled only in IDLE
- white_data  input  64  white occupancy, bit i = square i
- black_data  input  64  black occupancy, bit i = square i
- busy  output  1  high in COUNT and DONE
- done  output  1  one-cycle pulse when results update
- cnt_white  output  8  white stone total
- cnt_black  output  8  black stone total
- cnt_empty  output  8  empty squares
- winner  output  2  00 draw, 01 white, 10 black, 11 unused
- board_full  output  1  cnt_empty == 0
- err_overlap  output  1  some square set in both boards

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; row index = 0; accumulators = 0.
  - All outputs 0: cnt_*, winner = 00, board_full, err_overlap, busy, done.
- FSM states:
  - IDLE -> COUNT when start = 1 at a clock edge (edge T).
    - At edge T, latch white_data and black_data into shadow registers, clear the accumulators and the overlap flag, and set row = 0.
  - COUNT, at edges T+1 .. T+8:
    - Add popcount(shadow_w[8r+7:8r]) to acc_w and popcount(shadow_b[8r+7:8r]) to acc_b.
    - OR in |(shadow_w row & shadow_b row) to the overlap flag.
    - Increment r.
    - At the edge that processes r = 7 (T+8), go to DONE and register the results.
  - DONE: lasts one cycle, then returns to IDLE at edge T+9.
- Result outputs register at edge T+8 and are visible together:
  - cnt_white = acc_w, cnt_black = acc_b.
  - cnt_empty = 64 − w − b when w + b ≤ 64, else 0 (saturated; only possible with overlap).
  - winner: w > b → 01, b > w → 10, equal → 00.
  - board_full = (cnt_empty == 0).
  - err_overlap = overlap flag.
- Handshake and output timing:
  - done is high exactly in the DONE cycle, i.e. visible after edge T+8.
  - Latency from the accepted start edge to done visible is 8 cycles. The minimum period between accepted starts is 10 cycles.
  - busy = 1 in COUNT and DONE.
  - Result outputs hold their previous values throughout COUNT and change only at the transition into DONE.
- Boundary conditions:
  - start while busy (COUNT or DONE): ignored, not queued.
  - start held continuously high: accepted again in the first IDLE cycle after DONE.
  - Input boards changing during COUNT: no effect, because the shadow copies are used.
  - Width: the maximum per-colour total is 64. 8-bit accumulators cannot overflow, and w + b is computed at 8 bits since the maximum is 128.
  - rst_n asserted mid-COUNT: immediate return to reset values, no done pulse. The previous results are lost, and the outputs are 0.

Decomposition:
- Shared package reversi_pkg holds:
  - N_SQ and ROW_W;
  - winner encodings WIN_DRAW = 2'b00, WIN_WHITE = 2'b01, WIN_BLACK = 2'b10;
  - FSM state encodings S_IDLE, S_COUNT, S_DONE.
- Sub-module row_popcnt: combinational, 8-bit input to 4-bit count (0..8). Instantiated twice, once per colour, and shared across all rows by the sequencer.
- Row selection uses an indexed part-select on the shadow registers.

Test Plan:
- Opening position: white = 64'h0000_0010_0800_0000, black = 64'h0000_0008_1000_0000, start pulse at edge T.
  - Expect busy from T; done only in the cycle after T+8.
  - Expect cnt_white = 2, cnt_black = 2, cnt_empty = 60, winner = 00, board_full = 0, err_overlap = 0.
- Full board: white = all ones, black = 0.
  - Expect 64 / 0 / 0, winner = 01, board_full = 1.
  - Repeat with white = 64'hFFFF_FFFF_0000_0000 and black = 64'h0000_0000_FFFF_FFFF: expect 32 / 32 / 0, winner = 00, board_full = 1.
- Overlap: white = black = 64'h0000_0000_0000_00FF.
  - Expect cnt_white = 8, cnt_black = 8, cnt_empty = 48, err_overlap = 1.
  - Then all ones in both boards: expect cnt_empty = 0 (saturated) and err_overlap = 1.
- Start held high plus board change mid-count:
  - Start 1 forever; at edge T+3 change black to all ones.
  - First result uses the latched boards. The second start is accepted at edge T+10, and its done appears after edge T+18.
  - start pulses during busy produce no extra done.
- Reset mid-count: start, then rst_n low between edges T+4 and T+5.
  - Outputs go to 0 immediately (asynchronously), with no done.
  - After release, a new start gives a correct result 8 cycles later.
- Black win: white = 64'h1, black = 64'h6.
  - Expect 1 / 2 / 61, winner = 10.
  - Result outputs stay at their previous values until done.
